// File: rtl/acq_uart_tx.sv
// -----------------------------------------------------------------------------
// acq_uart_tx
//
// Purpose:
//   This block drains bytes from an upstream storage block and sends each one as
//   an asynchronous serial frame on TxD. The frame is LSB first, with one start
//   bit, eight data bits, an optional even-parity bit and one stop bit. A byte is
//   taken from upstream with a single ReadEnable pulse. The block then waits a
//   short settle period so that upstream can present its next DataOut and
//   DataReady before they are sampled again.
//
// Build option:
//   ACQ_UART_TX_PARITY_EN  When defined, a PARITY_BIT state follows DATA_BITS and
//                          drives the even parity of the data byte (8E1). When
//                          undefined, the frame is plain 8N1 and the block
//                          contains no parity logic.
//
// Parameters:
//   CLKS_PER_BIT   clk cycles per UART bit period (>= 4)
//   SETTLE_CYCLES  clk cycles spent in SETTLE after each frame (>= 3)
//
// Ports:
//   clk         in   single clock, shared with the upstream storage read side
//   rst_n       in   asynchronous active-low reset
//   DataOut     in   [7:0] byte offered by upstream
//   DataReady   in   DataOut holds a byte to transmit
//   TxEnable    in   flow control; low only prevents a new frame from starting
//   ReadEnable  out  one-cycle pulse that consumes the offered byte
//   TxD         out  serial line, idle high
//   Busy        out  high whenever the FSM is not in IDLE
//   BytesSent   out  [15:0] count of completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module acq_uart_tx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  DataOut,
    input  logic        DataReady,
    input  logic        TxEnable,
    output logic        ReadEnable,
    output logic        TxD,
    output logic        Busy,
    output logic [15:0] BytesSent
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
`ifdef ACQ_UART_TX_PARITY_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4,
        SETTLE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;     // position inside the current bit period
    logic [2:0]        bit_q,   bit_d;     // data bit index 0..7
    logic [7:0]        shift_q, shift_d;   // outgoing byte, bit 0 is on the line
    logic              re_q,    re_d;
    logic [15:0]       sent_q,  sent_d;
    logic [SET_W-1:0]  set_q,   set_d;     // cycles already spent in SETTLE
    logic              arm_q,   arm_d;     // set one edge after reset release
`ifdef ACQ_UART_TX_PARITY_EN
    logic              par_q,   par_d;     // even parity of the latched byte
`endif

    logic tmr_done;

    assign tmr_done = (tmr_q == TMR_LAST);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            re_q    <= 1'b0;
            sent_q  <= '0;
            set_q   <= '0;
            arm_q   <= 1'b0;
`ifdef ACQ_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            re_q    <= re_d;
            sent_q  <= sent_d;
            set_q   <= set_d;
            arm_q   <= arm_d;
`ifdef ACQ_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        re_d    = 1'b0;
        sent_d  = sent_q;
        set_d   = set_q;
        // arm_q ignores the first edge after reset release. Without it, a byte
        // could be taken on that same edge.
        arm_d   = 1'b1;
`ifdef ACQ_UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                bit_d = '0;
                set_d = '0;
                // The byte is captured here, so later changes on DataOut and
                // DataReady cannot disturb the frame. TxEnable is checked only
                // at this point, so a frame already in flight always completes.
                if (arm_q && DataReady && TxEnable) begin
                    shift_d = DataOut;
`ifdef ACQ_UART_TX_PARITY_EN
                    par_d   = ^DataOut;
`endif
                    re_d    = 1'b1;
                    state_d = START_BIT;
                end
            end

            START_BIT: begin
                if (tmr_done) begin
                    tmr_d   = '0;
                    state_d = DATA_BITS;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            DATA_BITS: begin
                if (tmr_done) begin
                    tmr_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef ACQ_UART_TX_PARITY_EN
                        state_d = PARITY_BIT;
`else
                        state_d = STOP_BIT;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

`ifdef ACQ_UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (tmr_done) begin
                    tmr_d   = '0;
                    state_d = STOP_BIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif

            STOP_BIT: begin
                if (tmr_done) begin
                    tmr_d   = '0;
                    set_d   = '0;
                    sent_d  = sent_q + 16'd1;
                    state_d = SETTLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            SETTLE: begin
                // The ReadEnable pulse always occurs at the start of the frame,
                // well before the stop bit ends. The settle window therefore
                // always starts when STOP_BIT is left.
                if (set_q == SET_LAST) begin
                    set_d   = '0;
                    state_d = IDLE;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                bit_d   = '0;
                set_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // TxD is decoded from registered state only, so reset forces the line high
    // immediately, without waiting for a clock edge.
    always_comb begin
        TxD = 1'b1;
        case (state_q)
            START_BIT:  TxD = 1'b0;
            DATA_BITS:  TxD = shift_q[0];
`ifdef ACQ_UART_TX_PARITY_EN
            PARITY_BIT: TxD = par_q;
`endif
            default:    TxD = 1'b1;
        endcase
    end

    assign ReadEnable = re_q;
    assign Busy       = (state_q != IDLE);
    assign BytesSent  = sent_q;

endmodule

// File: tb/tb_acq_uart_tx.sv
module tb_acq_uart_tx;

    localparam int CPB = 4;
    localparam int SET = 3;
`ifdef ACQ_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  DataOut;
    logic        DataReady;
    logic        TxEnable;
    logic        ReadEnable;
    logic        TxD;
    logic        Busy;
    logic [15:0] BytesSent;

    acq_uart_tx #(
        .CLKS_PER_BIT  (CPB),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .DataOut    (DataOut),
        .DataReady  (DataReady),
        .TxEnable   (TxEnable),
        .ReadEnable (ReadEnable),
        .TxD        (TxD),
        .Busy       (Busy),
        .BytesSent  (BytesSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_cnt;
    int          re_cnt = 0;
    int          exp_re = 0;
    logic        prev_re;
    logic [NB-1:0] last_bits;

    // Expected line pattern; bit i is the level during bit period i
    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef ACQ_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic offer(input logic [7:0] b);
        exp_q.push_back(b);
        exp_re++;
        DataOut   = b;
        DataReady = 1'b1;
    endtask

    task automatic wait_re(input string nm, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (ReadEnable !== 1'b1 && waited < 300);
        checks++;
        if (ReadEnable !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=timeout required=ReadEnable", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Busy !== 1'b0 && n < 300);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s actual=busy required=idle", nm);
        end
    endtask

    // Frame monitor: decodes TxD and checks each frame against the scoreboard
    initial begin : mon
        logic [NB-1:0] bits;
        logic          glitch;
        logic          abort;
        int            k;
        logic [7:0]    eb;
        exp_cnt = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 16'h0;
            end else if (TxD === 1'b0) begin
                bits   = '0;
                glitch = 1'b0;
                abort  = 1'b0;
                k      = 0;
                while (k < NB * CPB && !abort) begin
                    if (k != 0) @(negedge clk);
                    if (!rst_n) begin
                        abort = 1'b1;
                    end else begin
                        if (k % CPB == 0) bits[k / CPB] = TxD;
                        else if (TxD !== bits[k / CPB]) glitch = 1'b1;
                        k++;
                    end
                end
                if (abort) begin
                    exp_cnt = 16'h0;
                end else begin
                    @(negedge clk);
                    last_bits = bits;
                    chk("frame_timing", {31'd0, glitch}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h required=none", bits);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("frame_bits", {{(32-NB){1'b0}}, bits}, {{(32-NB){1'b0}}, frame_of(eb)});
                    end
                    exp_cnt = exp_cnt + 16'd1;
                    chk("bytes_sent", {16'd0, BytesSent}, {16'd0, exp_cnt});
                    chk("settle_busy", {31'd0, Busy}, 32'd1);
                end
            end
        end
    end

    // ReadEnable monitor: count the pulses and reject back-to-back highs
    initial begin : re_mon
        prev_re = 1'b0;
        forever begin
            @(negedge clk);
            if (ReadEnable === 1'b1) begin
                re_cnt++;
                chk("re_single", {31'd0, prev_re}, 32'd0);
            end
            prev_re = ReadEnable;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] stream [6];
        logic [9:0] a5_frame;
        int         w;
        int         re0;
        stream   = '{8'h80, 8'h02, 8'h12, 8'h34, 8'h80, 8'h01};
        a5_frame = 10'b1101001010;

        rst_n     = 1'b0;
        DataOut   = 8'h00;
        DataReady = 1'b0;
        TxEnable  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd",   {31'd0, TxD}, 32'd1);
        chk("rst_re",    {31'd0, ReadEnable}, 32'd0);
        chk("rst_busy",  {31'd0, Busy}, 32'd0);
        chk("rst_count", {16'd0, BytesSent}, 32'd0);

        // 0xA5 offered across the reset release: the first edge must not latch
        offer(8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arm_re",   {31'd0, ReadEnable}, 32'd0);
        chk("arm_busy", {31'd0, Busy}, 32'd0);
        wait_re("re_a5", w);
        chk("re_a5_latency", w, 32'd1);
        DataReady = 1'b0;
        wait_idle("idle_a5");
`ifndef ACQ_UART_TX_PARITY_EN
        chk("a5_sequence", {22'd0, last_bits}, {22'd0, a5_frame});
`endif
        chk("a5_count", {16'd0, BytesSent}, 32'd1);

        // Idle with nothing offered
        re0 = re_cnt;
        repeat (10) @(negedge clk);
        chk("idle_no_re", re_cnt - re0, 32'd0);
        chk("idle_txd",   {31'd0, TxD}, 32'd1);
        chk("idle_busy",  {31'd0, Busy}, 32'd0);

        // Stream with a one-cycle DataReady drop in IDLE before byte 5
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                DataReady = 1'b0;
                wait_idle("idle_before_drop");
                @(negedge clk);
                chk("drop_re",   {31'd0, ReadEnable}, 32'd0);
                chk("drop_busy", {31'd0, Busy}, 32'd0);
            end
            offer(stream[i]);
            wait_re("re_stream", w);
        end
        DataReady = 1'b0;
        wait_idle("idle_stream");
        chk("stream_count", {16'd0, BytesSent}, 32'd7);

`ifdef ACQ_UART_TX_PARITY_EN
        offer(8'h07);
        wait_re("re_par07", w);
        offer(8'h03);
        wait_re("re_par03", w);
        DataReady = 1'b0;
        wait_idle("idle_parity");
`endif

        // TxEnable dropped at bit 3 of 0x3C, with the next byte already offered
        offer(8'h3C);
        wait_re("re_3c", w);
        repeat (16) @(negedge clk);
        TxEnable = 1'b0;
        offer(8'h5A);
        wait_idle("idle_3c");
        re0 = re_cnt;
        repeat (20) @(negedge clk);
        chk("txen_block_re",   re_cnt - re0, 32'd0);
        chk("txen_block_busy", {31'd0, Busy}, 32'd0);
        TxEnable = 1'b1;
        wait_re("re_5a", w);
        chk("txen_resume_latency", w, 32'd1);
        DataReady = 1'b0;
        wait_idle("idle_5a");

        // Reset during DATA_BITS, while bit 0 (a zero) is on the line
        offer(8'h96);
        wait_re("re_96", w);
        DataReady = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_txd",   {31'd0, TxD}, 32'd1);
        chk("abort_busy",  {31'd0, Busy}, 32'd0);
        chk("abort_count", {16'd0, BytesSent}, 32'd0);
        chk("abort_re",    {31'd0, ReadEnable}, 32'd0);
        exp_q.delete(exp_q.size() - 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        offer(8'hC3);
        wait_re("re_c3", w);
        DataReady = 1'b0;
        wait_idle("idle_c3");
        chk("post_reset_count", {16'd0, BytesSent}, 32'd1);

        // Counter wrap: preload 0xFFFF, then send one more frame
        force dut.sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        offer(8'h55);
        wait_re("re_55", w);
        DataReady = 1'b0;
        wait_idle("idle_55");
        chk("wrap_count", {16'd0, BytesSent}, 32'd0);

        repeat (5) @(negedge clk);
        chk("re_total",    re_cnt, exp_re);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
